// File: rtl/eq_sweep_checker.sv
// Exhaustive sequencer and checker for an equality comparator: sweeps every (a,b) pair and checks Equal.
// Optional macro EQ_STOP_ON_FAIL_EN ends the sweep at the first mismatch, freezing the failing vector.
module eq_sweep_checker #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               eq_in,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_cnt,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   aOut_q, aOut_d;
    logic [WIDTH-1:0]   bOut_q, bOut_d;
    logic [WIDTH-1:0]   failA_q, failA_d;
    logic [WIDTH-1:0]   failB_q, failB_d;
    logic [2*WIDTH:0]   errCnt_q, errCnt_d;
    logic [3:0]         settleCnt_q, settleCnt_d;

    logic               expected;
    logic               mismatch;
    logic               lastVector;
    logic               stopNow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            aOut_q      <= '0;
            bOut_q      <= '0;
            failA_q     <= '0;
            failB_q     <= '0;
            errCnt_q    <= '0;
            settleCnt_q <= '0;
        end else begin
            state_q     <= state_d;
            aOut_q      <= aOut_d;
            bOut_q      <= bOut_d;
            failA_q     <= failA_d;
            failB_q     <= failB_d;
            errCnt_q    <= errCnt_d;
            settleCnt_q <= settleCnt_d;
        end
    end

    assign expected   = (aOut_q == bOut_q);
    assign mismatch   = (eq_in != expected);
    assign lastVector = (&aOut_q) && (&bOut_q);

`ifdef EQ_STOP_ON_FAIL_EN
    assign stopNow = mismatch || lastVector;
`else
    assign stopNow = lastVector;
`endif

    always_comb begin
        state_d     = state_q;
        aOut_d      = aOut_q;
        bOut_d      = bOut_q;
        failA_d     = failA_q;
        failB_d     = failB_q;
        errCnt_d    = errCnt_q;
        settleCnt_d = settleCnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = DRIVE;
                    aOut_d      = '0;
                    bOut_d      = '0;
                    failA_d     = '0;
                    failB_d     = '0;
                    errCnt_d    = '0;
                    settleCnt_d = '0;
                end
            end
            DRIVE: begin
                settleCnt_d = settleCnt_q + 4'd1;
                if (settleCnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    errCnt_d = errCnt_q + 1'b1;
                    if (errCnt_q == '0) begin
                        failA_d = aOut_q;
                        failB_d = bOut_q;
                    end
                end
                // Operands are left untouched on the final vector so they read back as its value.
                if (stopNow) begin
                    state_d = DONE;
                end else begin
                    state_d     = DRIVE;
                    settleCnt_d = '0;
                    bOut_d      = bOut_q + 1'b1;
                    if (&bOut_q) begin
                        aOut_d = aOut_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign a_out   = aOut_q;
    assign b_out   = bOut_q;
    assign busy    = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done    = (state_q == DONE);
    assign pass    = done && (errCnt_q == '0);
    assign err_cnt = errCnt_q;
    assign fail_a  = failA_q;
    assign fail_b  = failB_q;

endmodule

// File: tb/tb_eq_sweep_checker.sv
// Self-checking bench for eq_sweep_checker: a behavioural comparator with selectable faults drives eq_in,
// and a reference sweep model pushes expected end-of-sweep results to a scoreboard queue.
module tb_eq_sweep_checker;

    localparam int WIDTH   = 4;
    localparam int TIMEOUT = 2000;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             eqIn;
    logic [WIDTH-1:0] aOut;
    logic [WIDTH-1:0] bOut;
    logic             busy;
    logic             done;
    logic             pass;
    logic [2*WIDTH:0] errCnt;
    logic [WIDTH-1:0] failA;
    logic [WIDTH-1:0] failB;

    int faultMode;
    int checks;
    int errors;
    int sweepCycles;

    typedef struct {
        int errCnt;
        int pass;
        int failA;
        int failB;
        int lastA;
        int lastB;
        int cycles;
    } expect_t;

    expect_t scoreboard[$];

    eq_sweep_checker #(.WIDTH(WIDTH), .SETTLE(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .eq_in   (eqIn),
        .a_out   (aOut),
        .b_out   (bOut),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .err_cnt (errCnt),
        .fail_a  (failA),
        .fail_b  (failB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparator under test: 0 correct, 1 stuck-at-0, 2 stuck-at-1, 3 inverted only at a=3,b=5.
    function automatic logic comparatorModel(int mode, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return ((a == 4'd3) && (b == 4'd5)) ? ~(a == b) : (a == b);
            default: return (a == b);
        endcase
    endfunction

    assign eqIn = comparatorModel(faultMode, aOut, bOut);

    // Reference sweep: two cycles per vector, b fastest, first mismatch captured.
    function automatic expect_t modelSweep(int mode);
        expect_t e;
        logic [WIDTH-1:0] a, b;
        e.errCnt = 0; e.failA = 0; e.failB = 0; e.lastA = 15; e.lastB = 15; e.cycles = 0;
        for (int v = 0; v < 256; v++) begin
            a = 4'(v / 16);
            b = 4'(v % 16);
            e.cycles += 2;
            if (comparatorModel(mode, a, b) !== (a == b)) begin
                e.errCnt++;
                if (e.errCnt == 1) begin
                    e.failA = int'(a);
                    e.failB = int'(b);
                end
`ifdef EQ_STOP_ON_FAIL_EN
                e.lastA = int'(a);
                e.lastB = int'(b);
                break;
`else
`endif
            end
        end
        e.pass = (e.errCnt == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Push the expectation, pulse start, then run until done rises (bounded).
    task automatic applyStimulus(input int mode, input bit checkSeq, input bit spuriousStart);
        faultMode = mode;
        scoreboard.push_back(modelSweep(mode));
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_done_low", done, 0);
        check("start_busy", busy, 1);
        check("start_err_clear", errCnt, 0);
        check("start_faila_clear", failA, 0);
        check("start_failb_clear", failB, 0);
        check("start_a_zero", aOut, 0);
        check("start_b_zero", bOut, 0);
        sweepCycles = 0;
        while (!done && sweepCycles < TIMEOUT) begin
            @(posedge clk);
            #1;
            sweepCycles++;
            start = (spuriousStart && (sweepCycles == 10 || sweepCycles == 300));
            if (checkSeq && busy && (sweepCycles % 2 == 0)) begin
                check("seq_a", aOut, (sweepCycles / 2) / 16);
                check("seq_b", bOut, (sweepCycles / 2) % 16);
            end
        end
        start = 1'b0;
        check("done_rise", done, 1);
    endtask

    // Pop the oldest expectation and compare against the finished sweep.
    task automatic checkOutput();
        expect_t e;
        checks++;
        assert (scoreboard.size() > 0)
        else begin
            errors++;
            $error("[TB] FAIL scoreboard_empty observed 0 expected 1");
        end
        if (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            check("cycles", sweepCycles, e.cycles);
            check("err_cnt", errCnt, e.errCnt);
            check("pass", pass, e.pass);
            check("fail_a", failA, e.failA);
            check("fail_b", failB, e.failB);
            check("last_a", aOut, e.lastA);
            check("last_b", bOut, e.lastB);
            check("busy_low", busy, 0);
        end
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, "_a"}, aOut, 0);
        check({tag, "_b"}, bOut, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err"}, errCnt, 0);
        check({tag, "_faila"}, failA, 0);
        check({tag, "_failb"}, failB, 0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        faultMode = 0;
        start     = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] correct comparator sweep");
        applyStimulus(0, 1'b1, 1'b0);
        checkOutput();

        $display("[TB] stuck-at-0 comparator");
        applyStimulus(1, 1'b0, 1'b0);
        checkOutput();

        $display("[TB] single inverted vector, restart from DONE, spurious starts");
        applyStimulus(3, 1'b0, 1'b1);
        checkOutput();

        $display("[TB] stuck-at-1 comparator");
        applyStimulus(2, 1'b0, 1'b0);
        checkOutput();

        $display("[TB] reset mid-sweep");
        faultMode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        check("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        checkResetValues("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_idle", busy, 0);

        applyStimulus(3, 1'b0, 1'b0);
        checkOutput();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
